pulse_period_meter: RTL



---
 rtl/pulse_period_meter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//
// Measures the spacing between rising edges of a periodic strobe, in clk
// cycles. This is the receive side of a tick/strobe link: a divider turns a
// cycle count into a pulse train, and this block turns the pulses back into
// a cycle count. Use it for tick-rate checks and stalled-source detection.
//
// Parameters:
//   CNT_W       width of the period counter and of period_out
//   MAX_PERIOD  timeout threshold in clk cycles, 2 <= MAX_PERIOD < 2**CNT_W
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   pulse_in      strobe to measure, asynchronous to clk
//   period_out    last measured period (or 4-period mean), held between updates
//   period_valid  one-cycle strobe when period_out updates
//   locked        a valid period has been reported since reset/timeout
//   timeout       level, high while no edge has arrived for MAX_PERIOD cycles
//
// Build option:
//   PULSE_PERIOD_METER_AVG_EN  when defined, period_out is the truncated mean
//                              of the last 4 periods. Valid and locked appear
//                              only once 4 periods have been collected.
module pulse_period_meter #(
   parameter int CNT_W      = 28,
   parameter int MAX_PERIOD = 200_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

   state_t           state, state_nxt;
   logic             sync1, sync2, prev;
   logic             rise;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             meas;       // a period completes this cycle
   logic             tmo_enter;  // MAX_PERIOD reached without an edge

   // Two-flop synchronizer, then one more stage for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= pulse_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      meas      = 1'b0;
      tmo_enter = 1'b0;
      case (state)
         IDLE: begin
            // First edge only arms the counter.
            if (rise) begin
               state_nxt = MEASURE;
               cnt_nxt   = ONE;
            end
         end
         MEASURE: begin
            // An edge coinciding with cnt == MAX_CNT still counts as a period.
            if (rise) begin
               meas    = 1'b1;
               cnt_nxt = ONE;
            end else if (cnt >= MAX_CNT) begin
               state_nxt = TIMEOUT;
               tmo_enter = 1'b1;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         TIMEOUT: begin
            // Re-arm without reporting; the span since the last edge is unknown.
            if (rise) begin
               state_nxt = MEASURE;
               cnt_nxt   = ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         timeout <= (state_nxt == TIMEOUT);
      end
   end

`ifdef PULSE_PERIOD_METER_AVG_EN
   logic [CNT_W-1:0] hist [4];
   logic [CNT_W+1:0] sum, sum_nxt;
   logic [2:0]       fill;

   // Running sum: add the new period, drop the oldest. Until the buffer has
   // filled, the oldest slot is still zero from the last clear.
   assign sum_nxt = sum + {2'b00, cnt} - {2'b00, hist[3]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_out   <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         sum          <= '0;
         fill         <= '0;
         for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else begin
         period_valid <= 1'b0;
         if (tmo_enter) begin
            locked <= 1'b0;
            sum    <= '0;
            fill   <= '0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
         end else if (meas) begin
            hist[0] <= cnt;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            sum     <= sum_nxt;
            if (fill != 3'd4) fill <= fill + 3'd1;
            if (fill >= 3'd3) begin
               period_out   <= sum_nxt[CNT_W+1:2];
               period_valid <= 1'b1;
               locked       <= 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_out   <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
      end else begin
         period_valid <= meas;
         if (meas) begin
            period_out <= cnt;
            locked     <= 1'b1;
         end else if (tmo_enter) begin
            locked <= 1'b0;
         end
      end
   end
`endif

endmodule
